// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory and its loader.
// Memory geometry constants and the loader state encoding.
package imem_pkg;

  localparam int MEM_BYTES  = 1024;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    CHECK   = 3'd3,
    DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word packer: the first byte lands in bits 7:0, one byte per edge.
// word_full is combinational with the 4th accepted byte; the caller throttles via byte_vld.
module byte_packer
  import imem_pkg::*;
(
  input  logic        CLK,
  input  logic        Reset,
  input  logic        clear,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic        word_full,
  output logic [31:0] word_dat
);

  logic [1:0] lane;

  assign word_full = byte_vld && (lane == 2'(WORD_BYTES - 1));

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      lane     <= '0;
      word_dat <= '0;
    end else if (clear) begin
      lane     <= '0;
      word_dat <= '0;
    end else if (byte_vld) begin
      word_dat[8*lane +: 8] <= byte_dat;
      lane                  <= lane + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a byte-wise program into instruction memory, one write plus read-back check per word.
// At least 6 cycles per word; ByteReady is low during WRITE/CHECK and whenever not loading.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MEM_BYTES = 1024,
  parameter int          CNT_W     = 9
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [CNT_W-1:0] WordCount,
  input  logic             ByteValid,
  input  logic [7:0]       ByteData,
  output logic             ByteReady,
  output logic             MemRW,
  output logic [31:0]      MemAddr,
  output logic [31:0]      MemDataIn,
  input  logic [31:0]      MemDataOut,
  output logic             Busy,
  output logic             Done,
  output logic             Error,
  output logic             CpuHold
);

  import imem_pkg::*;

  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(MEM_BYTES / WORD_BYTES);

  state_e           state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] index;
  logic [CNT_W-1:0] next_index;
  logic             start_acc;
  logic             byte_xfer;
  logic             word_full;

  assign start_acc  = (state == IDLE) && Start;
  assign byte_xfer  = ByteValid && ByteReady;
  assign next_index = index + CNT_W'(1);
  assign CpuHold    = Busy;

  // The packer's register doubles as the write-data output, so it is stable through WRITE and CHECK.
  byte_packer u_packer (
    .CLK       (CLK),
    .Reset     (Reset),
    .clear     (start_acc),
    .byte_vld  (byte_xfer),
    .byte_dat  (ByteData),
    .word_full (word_full),
    .word_dat  (MemDataIn)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      count     <= '0;
      index     <= '0;
      ByteReady <= 1'b0;
      MemRW     <= 1'b0;
      MemAddr   <= BASE_ADDR;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Error     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Start) begin
            Done  <= 1'b0;
            Error <= 1'b0;
            count <= WordCount;
            index <= '0;
            if (WordCount == '0) begin
              Done  <= 1'b1;
              state <= DONE;
            end else if (WordCount > MAX_WORDS) begin
              Error <= 1'b1;
              Done  <= 1'b1;
              state <= DONE;
            end else begin
              Busy      <= 1'b1;
              ByteReady <= 1'b1;
              state     <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (word_full) begin
            ByteReady <= 1'b0;
            MemRW     <= 1'b1;
            MemAddr   <= BASE_ADDR + {{(32-CNT_W-2){1'b0}}, index, 2'b00};
            state     <= WRITE;
          end
        end
        WRITE: begin
          MemRW <= 1'b0;
          state <= CHECK;
        end
        CHECK: begin
          if (MemDataOut != MemDataIn) begin
            Error <= 1'b1;
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= DONE;
          end else if (next_index == count) begin
            index <= next_index;
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= DONE;
          end else begin
            index     <= next_index;
            ByteReady <= 1'b1;
            state     <= COLLECT;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          ByteReady <= 1'b0;
          MemRW     <= 1'b0;
          Busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a byte-array memory model on the write/read ports.
module tb_imem_loader;

  localparam int LIMIT = 100;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Start;
  logic [8:0]  WordCount;
  logic        ByteValid;
  logic [7:0]  ByteData;
  logic        ByteReady;
  logic        MemRW;
  logic [31:0] MemAddr;
  logic [31:0] MemDataIn;
  logic [31:0] MemDataOut;
  logic        Busy;
  logic        Done;
  logic        Error;
  logic        CpuHold;

  imem_loader #(
    .BASE_ADDR (32'h0000_0000),
    .MEM_BYTES (1024),
    .CNT_W     (9)
  ) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .Start      (Start),
    .WordCount  (WordCount),
    .ByteValid  (ByteValid),
    .ByteData   (ByteData),
    .ByteReady  (ByteReady),
    .MemRW      (MemRW),
    .MemAddr    (MemAddr),
    .MemDataIn  (MemDataIn),
    .MemDataOut (MemDataOut),
    .Busy       (Busy),
    .Done       (Done),
    .Error      (Error),
    .CpuHold    (CpuHold)
  );

  always #5 CLK = ~CLK;

  logic [7:0] mem [0:1023];
  logic [9:0] wa;
  bit         force_zero;

  assign wa         = {MemAddr[9:2], 2'b00};
  assign MemDataOut = force_zero ? 32'h0 : {mem[wa + 10'd3], mem[wa + 10'd2], mem[wa + 10'd1], mem[wa]};

  always @(posedge CLK) begin
    if (MemRW) begin
      for (int i = 0; i < 4; i++) mem[wa + 10'(i)] <= MemDataIn[8*i +: 8];
    end
  end

  function automatic logic [31:0] mem_word(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  typedef struct {
    logic [8:0]  cnt;
    int          nbytes;
    logic [63:0] bytes;
    bit          gaps;
    int          exp_writes;
    logic [31:0] exp_w0;
    logic [31:0] exp_w1;
    bit          exp_err;
    bit          exp_busy;
  } vec_t;

  vec_t vecs [5];

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] wr_addr [$];
  logic [31:0] wr_data [$];
  bit          busy_seen, br_seen, in_load;
  int          hold_mismatch, hold_low, timeouts;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Every wait goes through here so the observation flags are updated at one point per cycle.
  task automatic tick();
    @(negedge CLK);
    if (MemRW) begin
      wr_addr.push_back(MemAddr);
      wr_data.push_back(MemDataIn);
    end
    if (Busy) busy_seen = 1'b1;
    if (ByteReady) br_seen = 1'b1;
    if (CpuHold !== Busy) hold_mismatch++;
    if (in_load && !Done && CpuHold !== 1'b1) hold_low++;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    busy_seen = 1'b0;
    br_seen = 1'b0;
    hold_mismatch = 0;
    hold_low = 0;
    timeouts = 0;
  endtask

  task automatic start_load(input logic [8:0] cnt);
    Start = 1'b1;
    WordCount = cnt;
    tick();
    Start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int g;
    if (gaps) repeat ($urandom_range(0, 3)) tick();
    ByteValid = 1'b1;
    ByteData = b;
    g = 0;
    while (!ByteReady && g < LIMIT) begin
      tick();
      g++;
    end
    if (g >= LIMIT) timeouts++;
    tick();
    ByteValid = 1'b0;
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (!Done && g < LIMIT) begin
      tick();
      g++;
    end
    if (g >= LIMIT) timeouts++;
  endtask

  task automatic run_vec(input vec_t v);
    clear_log();
    start_load(v.cnt);
    if (!v.exp_busy) check("done_next_cycle", Done, 1'b1);
    in_load = v.exp_busy;
    for (int i = 0; i < v.nbytes; i++) send_byte(v.bytes[8*i +: 8], v.gaps);
    wait_done();
    in_load = 1'b0;
    check("done", Done, 1'b1);
    check("error", Error, v.exp_err);
    repeat (2) tick();
    check("done_held", Done, 1'b1);
    check("write_count", wr_addr.size(), v.exp_writes);
    if (v.exp_writes > 0 && wr_addr.size() > 0) begin
      check("w0_addr", wr_addr[0], 32'h0);
      check("w0_data", wr_data[0], v.exp_w0);
    end
    if (v.exp_writes > 1 && wr_addr.size() > 1) begin
      check("w1_addr", wr_addr[1], 32'h4);
      check("w1_data", wr_data[1], v.exp_w1);
      check("mem_word1", mem_word(4), v.exp_w1);
    end
    if (v.exp_writes > 0) check("mem_word0", mem_word(0), v.exp_w0);
    check("busy_seen", busy_seen, v.exp_busy);
    check("byteready_seen", br_seen, v.exp_busy);
    check("cpuhold_eq_busy", hold_mismatch, 0);
    check("cpuhold_in_load", hold_low, 0);
    check("cpuhold_after", CpuHold, 1'b0);
    check("timeouts", timeouts, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{cnt: 9'd1,   nbytes: 4, bytes: 64'h0000_0000_4433_2211, gaps: 1'b0,
                exp_writes: 1, exp_w0: 32'h4433_2211, exp_w1: 32'h0, exp_err: 1'b0, exp_busy: 1'b1};
    vecs[1] = '{cnt: 9'd2,   nbytes: 8, bytes: 64'h0403_0201_DDCC_BBAA, gaps: 1'b1,
                exp_writes: 2, exp_w0: 32'hDDCC_BBAA, exp_w1: 32'h0403_0201, exp_err: 1'b0, exp_busy: 1'b1};
    vecs[2] = '{cnt: 9'd0,   nbytes: 0, bytes: 64'h0, gaps: 1'b0,
                exp_writes: 0, exp_w0: 32'h0, exp_w1: 32'h0, exp_err: 1'b0, exp_busy: 1'b0};
    vecs[3] = '{cnt: 9'd257, nbytes: 0, bytes: 64'h0, gaps: 1'b0,
                exp_writes: 0, exp_w0: 32'h0, exp_w1: 32'h0, exp_err: 1'b1, exp_busy: 1'b0};
    vecs[4] = '{cnt: 9'd1,   nbytes: 4, bytes: 64'h0000_0000_EFBE_ADDE, gaps: 1'b1,
                exp_writes: 1, exp_w0: 32'hEFBE_ADDE, exp_w1: 32'h0, exp_err: 1'b0, exp_busy: 1'b1};

    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    force_zero = 1'b0;
    in_load = 1'b0;
    Reset = 1'b1;
    Start = 1'b0;
    WordCount = '0;
    ByteValid = 1'b0;
    ByteData = '0;
    clear_log();

    #12;
    check("rst_byteready", ByteReady, 1'b0);
    check("rst_memrw", MemRW, 1'b0);
    check("rst_memaddr", MemAddr, 32'h0);
    check("rst_memdatain", MemDataIn, 32'h0);
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_error", Error, 1'b0);
    check("rst_cpuhold", CpuHold, 1'b0);
    @(negedge CLK);
    Reset = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) run_vec(vecs[v]);

    // Read-back corrupted during CHECK of word 0: abort with Error and no further byte requests.
    clear_log();
    force_zero = 1'b1;
    start_load(9'd2);
    send_byte(8'h78, 1'b0);
    send_byte(8'h56, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h12, 1'b0);
    wait_done();
    check("abort_error", Error, 1'b1);
    check("abort_done", Done, 1'b1);
    check("abort_writes", wr_addr.size(), 1);
    if (wr_data.size() > 0) check("abort_w0_data", wr_data[0], 32'h1234_5678);
    force_zero = 1'b0;
    br_seen = 1'b0;
    ByteValid = 1'b1;
    repeat (5) tick();
    ByteValid = 1'b0;
    check("abort_no_byteready", br_seen, 1'b0);
    check("abort_busy", Busy, 1'b0);
    check("abort_timeouts", timeouts, 0);

    // Largest legal count starts a real load.
    start_load(9'd256);
    check("max_cnt_busy", Busy, 1'b1);
    check("max_cnt_error", Error, 1'b0);
    check("max_cnt_byteready", ByteReady, 1'b1);

    // Reset after two of four bytes: outputs drop immediately and memory is untouched.
    Reset = 1'b1;
    #1;
    clear_log();
    Reset = 1'b0;
    tick();
    start_load(9'd1);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A, 1'b0);
    Reset = 1'b1;
    #1;
    check("midrst_memrw", MemRW, 1'b0);
    check("midrst_busy", Busy, 1'b0);
    check("midrst_cpuhold", CpuHold, 1'b0);
    check("midrst_byteready", ByteReady, 1'b0);
    check("midrst_memaddr", MemAddr, 32'h0);
    repeat (2) tick();
    Reset = 1'b0;
    repeat (2) tick();
    check("midrst_writes", wr_addr.size(), 0);
    check("midrst_mem_unchanged", mem_word(0), 32'h1234_5678);

    // Fresh load after the reset must start again at the base address.
    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
